// File: rtl/pattern_pkg.sv
// Shared encodings and default sizing for the pattern-scan scheduler.
package pattern_pkg;
  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  // One-hot, matching the detector's state style
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SHIFT = 4'b0010,
    DRAIN = 4'b0100,
    DONE  = 4'b1000
  } state_t;
endpackage

// File: rtl/pattern_scan_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_id,
  output logic            any
);
  int idx;

  always_comb begin
    win    = '0;
    win_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        win[idx] = 1'b1;
        win_id   = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/pattern_scan_sched.sv
// Shares one serial 1011 detector among NREQ requesters: grant, shift word
// MSB-first, count detector hits, report count with requester ID.
module pattern_scan_sched
  import pattern_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDW   = $clog2(NREQ),
  localparam int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  det_rst,
  output logic                  det_in,
  output logic                  det_valid,
  input  logic                  det_out,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CNTW-1:0]       match_cnt
);
  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, id_q, win_id, ptr_nxt;
  logic [NREQ-1:0]   win, gnt_q;
  logic              any, valid_d, inc;
  logic [WIDTH-1:0]  shreg_q;
  logic [CNTW-1:0]   bit_q, cnt_q, cnt_nxt, match_q;
  logic [IDW-1:0]    done_id_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .win    (win),
    .win_id (win_id),
    .any    (any)
  );

  assign ptr_nxt = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  // Detector output is registered, so a hit belongs to the bit sent one cycle earlier
  assign inc     = valid_d & det_out;
  assign cnt_nxt = (inc && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;

  assign busy      = (state_q != IDLE);
  assign det_rst   = (state_q == IDLE);
  assign det_valid = (state_q == SHIFT);
  assign det_in    = (state_q == SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
  assign done      = (state_q == DONE);
  assign gnt       = gnt_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = SHIFT;
      SHIFT:   if (bit_q == CNTW'(WIDTH - 1)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      cnt_q     <= '0;
      valid_d   <= 1'b0;
      gnt_q     <= '0;
      match_q   <= '0;
      done_id_q <= '0;
    end else begin
      state_q <= state_d;
      valid_d <= det_valid;
      gnt_q   <= '0;
      cnt_q   <= cnt_nxt;
      case (state_q)
        IDLE: if (any) begin
          shreg_q <= req_data[win_id*WIDTH +: WIDTH];
          id_q    <= win_id;
          ptr_q   <= ptr_nxt;
          gnt_q   <= win;
          cnt_q   <= '0;
          bit_q   <= '0;
        end
        SHIFT: begin
          shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          bit_q   <= bit_q + CNTW'(1);
        end
        // Last detector hit arrives during DRAIN; fold it into the result
        DRAIN: begin
          match_q   <= cnt_nxt;
          done_id_q <= id_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_scan_sched.sv
// Directed bench for pattern_scan_sched with a behavioural 1011 detector.
module tb_pattern_scan_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       gnt;
  logic                  busy, det_rst, det_in, det_valid, det_out, done;
  logic [1:0]            done_id;
  logic [3:0]            match_cnt;

  logic                  force_hi = 1'b0;
  logic [1:0]            dst;
  logic                  mout;
  int                    cyc = 0;
  int                    checks = 0;
  int                    errors = 0;

  pattern_scan_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .busy      (busy),
    .det_rst   (det_rst),
    .det_in    (det_in),
    .det_valid (det_valid),
    .det_out   (det_out),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Non-overlapping 1011 detector, registered out, holds out while not valid
  always @(posedge clk) begin
    if (det_rst) begin
      dst  <= 2'd0;
      mout <= 1'b0;
    end else if (det_valid) begin
      mout <= (dst == 2'd3) && det_in;
      case (dst)
        2'd0: dst <= det_in ? 2'd1 : 2'd0;
        2'd1: dst <= det_in ? 2'd1 : 2'd2;
        2'd2: dst <= det_in ? 2'd3 : 2'd0;
        default: dst <= det_in ? 2'd0 : 2'd2;
      endcase
    end
  end
  assign det_out = force_hi | mout;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_det_rst"}, int'(det_rst), 1);
    chk({tag, "_det_in"}, int'(det_in), 0);
    chk({tag, "_det_valid"}, int'(det_valid), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_done_id"}, int'(done_id), 0);
    chk({tag, "_match_cnt"}, int'(match_cnt), 0);
  endtask

  task automatic wait_gnt(output int at, output int saw_done);
    saw_done = 0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (gnt != '0) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("gnt_timeout", 0, 1);
  endtask

  // Waits for grant of requester id, then checks the full serial job timing.
  task automatic finish_job(input int id, input logic [7:0] data, input int exp_cnt);
    int at, sd;
    logic [3:0] exp_gnt;
    wait_gnt(at, sd);
    exp_gnt = '0;
    exp_gnt[id] = 1'b1;
    chk("no_spurious_done", sd, 0);
    chk("gnt_onehot", int'(gnt), int'(exp_gnt));
    chk("busy_in_shift", int'(busy), 1);
    req[id] = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("det_in_k%0d", k), int'(det_in), int'(data[WIDTH-1-k]));
      chk($sformatf("det_valid_k%0d", k), int'(det_valid & ~det_rst), 1);
      force_hi = 1'b0;
    end
    @(negedge clk);
    chk("drain_valid", int'(det_valid), 0);
    chk("drain_done", int'(done), 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 1);
    chk("done_id", int'(done_id), id);
    chk("match_cnt", int'(match_cnt), exp_cnt);
  endtask

  initial begin
    int at, sd, prev, wid;
    int exp_cnt[4];
    logic [7:0] words[4];
    words   = '{8'hBB, 8'hDB, 8'h00, 8'hB0};
    exp_cnt = '{2, 1, 0, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("idle");

    // Single jobs
    req_data[0*8 +: 8] = 8'hBB; req[0] = 1'b1;
    finish_job(0, 8'hBB, 2);
    req_data[2*8 +: 8] = 8'hDB; req[2] = 1'b1;
    finish_job(2, 8'hDB, 1);
    req_data[1*8 +: 8] = 8'h00; req[1] = 1'b1;
    finish_job(1, 8'h00, 0);
    @(negedge clk);
    chk("done_drops", int'(done), 0);
    chk("match_cnt_hold", int'(match_cnt), 0);
    chk("done_id_hold", int'(done_id), 1);

    // Pointer now at 2: req 1 and 3 together, 3 wins first
    req_data[3*8 +: 8] = 8'hB0;
    req_data[1*8 +: 8] = 8'hBB;
    req[1] = 1'b1; req[3] = 1'b1;
    finish_job(3, 8'hB0, 1);
    finish_job(1, 8'hBB, 2);

    // det_out stuck high while not valid must not count
    @(negedge clk);
    force_hi = 1'b1;
    req_data[1*8 +: 8] = 8'h00; req[1] = 1'b1;
    finish_job(1, 8'h00, 0);
    force_hi = 1'b0;

    // Reset during SHIFT k=4, then re-grant of the still-pending request
    @(negedge clk);
    req_data[0*8 +: 8] = 8'hBB; req[0] = 1'b1;
    wait_gnt(at, sd);
    chk("pre_abort_gnt", int'(gnt), 1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_outs("abort");
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    rst = 1'b1;
    finish_job(0, 8'hBB, 2);
    req[0] = 1'b0;

    // All four held from reset: order 0,1,2,3,0 at 11-cycle spacing
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = words[i];
    req = '1;
    @(negedge clk);
    rst = 1'b1;
    prev = 0;
    for (int j = 0; j < 5; j++) begin
      wait_gnt(at, sd);
      wid = -1;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) wid = i;
      chk($sformatf("rr_order_%0d", j), wid, j % 4);
      if (j > 0) chk($sformatf("gnt_spacing_%0d", j), at - prev, 11);
      prev = at;
      if (j == 4) req = '0;
      sd = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin
          sd = 1;
          break;
        end
      end
      chk($sformatf("rr_done_seen_%0d", j), sd, 1);
      chk($sformatf("rr_done_lat_%0d", j), cyc - at, WIDTH + 1);
      chk($sformatf("rr_done_id_%0d", j), int'(done_id), j % 4);
      chk($sformatf("rr_cnt_%0d", j), int'(match_cnt), exp_cnt[j % 4]);
    end

    @(negedge clk);
    chk("final_idle", int'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_scan_sched.md
Name: pattern_scan_sched

Overview:
- Round-robin scheduler that shares one external bit-serial pattern detector (sync active-high reset, `in`/`valid`/registered `out`, 1011 Mealy type) among NREQ requesters.
- Each requester submits one WIDTH-bit word. The block clears the detector, shifts the word in MSB-first, counts `out` pulses and returns the match count with the requester ID.
- Sits between the stream front-ends and the single detector instance.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, bits per scan word (>=4)
IDW, $clog2(NREQ), requester ID width (derived)
CNTW, $clog2(WIDTH+1), match-count width (derived)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
req  input  NREQ  per-requester request level
req_data  input  NREQ*WIDTH  request words; requester i in bits [i*WIDTH +: WIDTH]
gnt  output  NREQ  one-hot grant pulse, one cycle
busy  output  1  high whenever state != IDLE
det_rst  output  1  detector sync reset, active-high
det_in  output  1  serial bit to detector
det_valid  output  1  detector bit qualifier
det_out  input  1  detector match output (registered in detector)
done  output  1  result pulse, one cycle
done_id  output  IDW  requester ID of the result
match_cnt  output  CNTW  matches found in the word

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, pointer=0, shift reg=0, counters=0, valid_d=0.
  - gnt=0, busy=0, det_in=0, det_valid=0, done=0, done_id=0, match_cnt=0.
  - det_rst=1.
- Reset mid-scan abandons the job silently: no done, no gnt. The requester keeps req high and is re-arbitrated after reset.
- State IDLE:
  - det_rst=1.
  - If any req is set, pick the first set bit at or after the pointer, searching upward with wrap.
  - On that edge: capture req_data of the winner, store its ID, set pointer=winner+1 mod NREQ, pulse gnt[winner] (registered, high during the first SHIFT cycle), go to SHIFT.
  - If no req is set, stay in IDLE; pointer is unchanged.
- State SHIFT, WIDTH cycles, bit index k=0..WIDTH-1:
  - det_rst=0, det_valid=1, det_in=word[WIDTH-1-k].
  - After k=WIDTH-1, go to DRAIN.
- State DRAIN, 1 cycle: det_valid=0, det_rst=0. Absorbs the detector's one-cycle output latency.
- State DONE, 1 cycle:
  - done=1; done_id and match_cnt hold the result.
  - Next state is IDLE. match_cnt and done_id hold their values until the next DONE.
- Match counting:
  - valid_d is det_valid delayed one cycle.
  - cnt increments when valid_d=1 and det_out=1, sampled in SHIFT k>=1 and in DRAIN.
  - det_out is ignored when valid_d=0, because the detector holds `out` while not valid.
  - cnt clears on grant.
  - cnt saturates at 2^CNTW-1. It cannot overflow by construction; the saturation is a guard only.
- Requester protocol:
  - Hold req high with stable req_data until gnt is seen.
  - Drop or re-raise req the cycle after gnt.
  - req held through done is treated as a new request and re-granted on a later arbitration.
- Timing:
  - gnt cycle = cycle G. done is high at cycle G+WIDTH+1 (WIDTH SHIFT cycles, then DRAIN, then DONE).
  - Minimum spacing between grants: WIDTH+3 cycles (SHIFT + DRAIN + DONE + IDLE).
  - The IDLE cycle guarantees one det_rst edge before every scan.
- Simultaneous requests: strict round-robin from the pointer. No requester waits more than NREQ-1 jobs.
- req changes during SHIFT/DRAIN/DONE are ignored until IDLE.

Decomposition:
- Shared package `pattern_pkg`: state encoding (IDLE/SHIFT/DRAIN/DONE, one-hot 4-bit, matching the detector's one-hot style) and the default WIDTH/NREQ constants.
- One sub-module: `rr_arbiter` (NREQ, req, pointer -> one-hot winner, winner ID, any). It is combinational with the pointer registered in the parent.

Test Plan:
- Single req[0], data 8'b1011_1011 -> gnt[0] at G, det_in sequence 1,0,1,1,1,0,1,1, done at G+9 with done_id=0, match_cnt=2.
- req[2] data 8'b1101_1011 -> match_cnt=1. req[1] data 8'h00 -> match_cnt=0. Each result returns done_id equal to the requester.
- All four req held from reset with distinct words -> grant order 0,1,2,3,0; gnt spacing exactly 11 cycles; each done_id matches the preceding gnt.
- Pointer at 2, req[1] and req[3] both raised -> req[3] granted first, then req[1].
- Assert rst=0 during SHIFT k=4 -> all outputs go to reset values immediately and det_rst=1. After release, the still-pending req is re-granted and returns the correct count with no spurious done.
- Force det_out=1 continuously from the detector model while det_valid=0 in IDLE -> match_cnt unaffected; only valid_d-qualified pulses are counted.
